// File: rtl/sl_transmitter.sv
// Sending end of the two-wire SL link: shifts an N-bit word LSB-first onto the
// zeroes/ones pair, followed by an odd-parity bit and a both-low stop symbol.
module sl_transmitter #(
  parameter int LOW_CYCLES  = 16,
  parameter int HIGH_CYCLES = 16,
  parameter int GAP_CYCLES  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] wr_config_w,
  input  logic [31:0] tx_data_w,
  input  logic        start_i,
  output logic        serial_line_zeroes_o,
  output logic        serial_line_ones_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] status_w
);

  typedef enum logic [2:0] {IDLE, BIT_LOW, BIT_HIGH, STOP_LOW, STOP_HIGH} state_t;

  localparam logic [5:0] LOW_LAST  = 6'(LOW_CYCLES - 1);
  localparam logic [5:0] HIGH_LAST = 6'(HIGH_CYCLES - 1);
  localparam logic [5:0] STOP_LAST = 6'(HIGH_CYCLES + GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [5:0]  cyc_q, cyc_d;
  logic [5:0]  bit_q, bit_d;
  logic [31:0] data_q, data_d;
  logic        par_q, par_d;
  logic [15:0] cfg_q, cfg_d;
  logic        zeroes_q, zeroes_d;
  logic        ones_q, ones_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        bqe_q, bqe_d;
  logic        ovr_q, ovr_d;
  logic        wsf_q, wsf_d;

  logic [5:0]  start_n;
  logic        start_ok;
  logic [31:0] masked;
  logic        bit_val;
  logic        unused_cfg;

  assign start_n    = wr_config_w[6:1];
  assign start_ok   = (start_n != 6'd0) && (start_n <= 6'd32);
  assign unused_cfg = ^{cfg_q[15:7], cfg_q[0]};

  always_comb begin
    for (int i = 0; i < 32; i++) masked[i] = tx_data_w[i] & (6'(i) < start_n);
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    data_d  = data_q;
    par_d   = par_q;
    cfg_d   = cfg_q;
    bqe_d   = bqe_q;
    ovr_d   = ovr_q;
    wsf_d   = wsf_q;
    done_d  = 1'b0;

    // A request in the done cycle still counts as overlapping the old frame.
    if (start_i && (busy_q || done_q)) ovr_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (start_i && !done_q) begin
          if (start_ok) begin
            state_d = BIT_LOW;
            cyc_d   = 6'd0;
            bit_d   = 6'd0;
            data_d  = masked;
            par_d   = ~^masked;
            cfg_d   = wr_config_w;
            bqe_d   = 1'b0;
            ovr_d   = 1'b0;
            wsf_d   = 1'b0;
          end else begin
            bqe_d  = 1'b1;
            done_d = 1'b1;
          end
        end
      end
      BIT_LOW: begin
        if (cyc_q == LOW_LAST) begin
          state_d = BIT_HIGH;
          cyc_d   = 6'd0;
        end else cyc_d = cyc_q + 6'd1;
      end
      BIT_HIGH: begin
        if (cyc_q == HIGH_LAST) begin
          cyc_d   = 6'd0;
          data_d  = data_q >> 1;
          bit_d   = bit_q + 6'd1;
          state_d = (bit_q < cfg_q[6:1]) ? BIT_LOW : STOP_LOW;
        end else cyc_d = cyc_q + 6'd1;
      end
      STOP_LOW: begin
        if (cyc_q == LOW_LAST) begin
          state_d = STOP_HIGH;
          cyc_d   = 6'd0;
        end else cyc_d = cyc_q + 6'd1;
      end
      STOP_HIGH: begin
        if (cyc_q == STOP_LAST) begin
          state_d = IDLE;
          cyc_d   = 6'd0;
          done_d  = 1'b1;
          wsf_d   = 1'b1;
        end else cyc_d = cyc_q + 6'd1;
      end
      default: state_d = IDLE;
    endcase

    // Line levels follow the next state so every output stays registered.
    bit_val  = (bit_d == cfg_d[6:1]) ? par_d : data_d[0];
    zeroes_d = ~(((state_d == BIT_LOW) && !bit_val) || (state_d == STOP_LOW));
    ones_d   = ~(((state_d == BIT_LOW) && bit_val) || (state_d == STOP_LOW));
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cyc_q    <= 6'd0;
      bit_q    <= 6'd0;
      data_q   <= 32'd0;
      par_q    <= 1'b0;
      cfg_q    <= 16'h0020;
      zeroes_q <= 1'b1;
      ones_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bqe_q    <= 1'b0;
      ovr_q    <= 1'b0;
      wsf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      bit_q    <= bit_d;
      data_q   <= data_d;
      par_q    <= par_d;
      cfg_q    <= cfg_d;
      zeroes_q <= zeroes_d;
      ones_q   <= ones_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      bqe_q    <= bqe_d;
      ovr_q    <= ovr_d;
      wsf_q    <= wsf_d;
    end
  end

  assign serial_line_zeroes_o = zeroes_q;
  assign serial_line_ones_o   = ones_q;
  assign busy_o               = busy_q;
  assign done_o               = done_q;
  assign status_w             = {13'd0, wsf_q, ovr_q, bqe_q};

endmodule

// File: doc/sl_transmitter.md
# sl_transmitter

Serial-line (SL) word transmitter, the sending end of the two-wire SL link. A 32-bit word is taken from the register side and driven LSB-first onto the `zeroes`/`ones` line pair, followed by a parity bit and a stop symbol, at a fixed cycle rate derived from the 16 MHz system clock. It sits beside the SL receiver in the SL transceiver and uses the same configuration-word layout.

## Interface
- `LOW_CYCLES`, 16: clock cycles a line is held low per symbol (active phase).
- `HIGH_CYCLES`, 16: clock cycles both lines are held high after each symbol (idle phase).
- `GAP_CYCLES`, 32: extra idle-high cycles after the stop symbol before `busy` drops.
- `clk`  in  1  system clock, 16 MHz.
- `rst`  in  1  asynchronous reset, active high.
- `wr_config_w`  in  16  config. bit0 PCE (parity check enable, informational only, parity always sent), bits[6:1] BQ (data bit count N), others ignored.
- `tx_data_w`  in  32  word to send. Bits [N-1:0] are used.
- `start_i`  in  1  request, sampled each cycle.
- `serial_line_zeroes_o`  out  1  zero line, idle high.
- `serial_line_ones_o`  out  1  one line, idle high.
- `busy_o`  out  1  word in progress.
- `done_o`  out  1  one-cycle pulse at word completion.
- `status_w`  out  16  bit0 BQE (illegal BQ at start), bit1 OVR (start while busy), bit2 WSF (word sent flag). Other bits 0.

## Operation
- Encoding per symbol, during the active phase only:
  - data/parity 1: ones line low, zeroes line high.
  - data/parity 0: zeroes line low, ones line high.
  - stop: both lines low.
- Each symbol is followed by `HIGH_CYCLES` with both lines high.
- Frame order: N data bits LSB first, then the parity bit, then stop. Parity = `~^tx_data_w[N-1:0]`, so the count of ones across data plus parity is odd.
- Legal N is 1..32. On `start_i` with N=0 or N>32: no frame is sent, BQE is set, and `done_o` pulses on the next cycle.
- `wr_config_w` and `tx_data_w` are latched into internal registers on acceptance. Later changes have no effect on the word in flight.
- States:
  - IDLE: lines high, `busy_o`=0. Accept on `start_i` with legal N, then go to BIT_LOW.
  - BIT_LOW: drive the current bit's line low for `LOW_CYCLES`, then go to BIT_HIGH.
  - BIT_HIGH: lines high for `HIGH_CYCLES`. Then shift the data register right, increment the bit counter, and go to BIT_LOW if sent bits < N+1, else STOP_LOW.
  - STOP_LOW: both low for `LOW_CYCLES`, then STOP_HIGH.
  - STOP_HIGH: both high for `HIGH_CYCLES + GAP_CYCLES`, then IDLE with a `done_o` pulse.
- Counters:
  - Cycle counter is 6 bits and is cleared on every phase change.
  - Bit counter is 6 bits and counts 0..N. Index N selects the parity bit.
- Status:
  - Acceptance clears BQE, OVR and WSF.
  - WSF is set with `done_o` on a good frame.
  - OVR is set by `start_i` while `busy_o`=1. That request is dropped and the current frame is unaffected.
  - Status bits are sticky until the next acceptance or reset.

## Timing
- Reset values: both lines 1, `busy_o`=0, `done_o`=0, `status_w`=0, state IDLE. The internal config register resets to 0x0020 (N=16, PCE=0).
- Reset asserted mid-frame drives both lines high on the assertion, with no wait for a clock edge. The frame is abandoned and no `done_o` pulse is produced.
- All outputs are registered.
- `start_i` sampled high at edge k:
  - `busy_o`=1 and the first low level appear after edge k.
  - Frame length = (N+2)·(`LOW_CYCLES`+`HIGH_CYCLES`) + `GAP_CYCLES` cycles.
  - `done_o` is high for exactly one cycle, in the cycle where `busy_o` returns to 0.
- `start_i` in the same cycle as the `done_o` pulse is treated as busy (OVR). A start is accepted only in IDLE.
- The two lines are never low simultaneously except in STOP_LOW. Both are high during every HIGH phase and in IDLE.

## Test plan
- Reset, then N=16, `tx_data_w`=0x0000_A5A5, one `start_i` pulse:
  - `ones` low pulses at bits 0,2,5,7,8,10,13,15.
  - Parity bit 1: eight ones, so it is sent on `ones`.
  - Stop: both low.
  - `done_o` at cycle 18·32+32=608. WSF=1.
- N=1, data=1:
  - Bit0 on `ones`, parity 0 on `zeroes`, then stop.
  - Frame is 3·32+32=128 cycles.
- N=32, data=0xFFFF_FFFF:
  - 32 `ones` pulses, then parity 1 (on `ones`), then stop.
  - `busy_o` high for 34·32+32 cycles.
- N=0 at start:
  - No line activity.
  - BQE=1, `done_o` one cycle after start, `busy_o` stays 0.
- `start_i` pulsed mid-frame, and `tx_data_w`/`wr_config_w` changed mid-frame:
  - OVR=1.
  - Waveform identical to the undisturbed frame.
- `rst` asserted during bit 5 of a frame:
  - Both lines high immediately, `busy_o`=0, status 0.
  - Next start sends a complete clean frame.
